// File: rtl/router_egress_arbiter_if.sv
// Egress arbiter bus bundle: FIFO-side pop/flush signals plus the shared egress stream.
// master = arbiter side, slave = FIFO bank / egress sink side.
interface router_egress_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  logic [2:0]          fifo_empty_i;
  logic [3*DATA_W-1:0] fifo_dout_i;
  logic [2:0]          fifo_rd_en_o;
  logic [2:0]          soft_reset_o;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [DATA_W-1:0]   out_data_o;
  logic [1:0]          out_chan_o;
  logic                out_sop_o;
  logic                out_eop_o;
  logic                busy_o;

  modport master (
    input  fifo_empty_i, fifo_dout_i, out_ready_i,
    output fifo_rd_en_o, soft_reset_o, out_valid_o, out_data_o, out_chan_o,
    output out_sop_o, out_eop_o, busy_o
  );

  modport slave (
    output fifo_empty_i, fifo_dout_i, out_ready_i,
    input  fifo_rd_en_o, soft_reset_o, out_valid_o, out_data_o, out_chan_o,
    input  out_sop_o, out_eop_o, busy_o
  );
endinterface

// File: rtl/router_egress_arbiter.sv
// Packet-granular round-robin drain of three first-word-fall-through FIFOs onto one egress bus.
// Define ROUTER_ARB_WATCHDOG_EN to flush a channel that makes no progress for TIMEOUT cycles.
module router_egress_arbiter #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic                    clock,
  input  logic                    resetn,
  router_egress_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StHdr, StBody} state_e;

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [6:0]        cnt_q, cnt_d;

  logic [DATA_W-1:0] head_data;
  logic              head_empty;
  logic              valid;
  logic              xfer;
  logic              timeout;
  logic [1:0]        pick;
  logic              pick_found;

  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
  endfunction

  function automatic logic [2:0] ch_onehot(input logic [1:0] ch);
    logic [2:0] oh;
    oh = 3'b000;
    case (ch)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Head word and empty flag of the granted channel.
  always_comb begin
    head_data  = '0;
    head_empty = 1'b1;
    case (grant_q)
      2'd0: begin
        head_data  = bus.fifo_dout_i[0*DATA_W +: DATA_W];
        head_empty = bus.fifo_empty_i[0];
      end
      2'd1: begin
        head_data  = bus.fifo_dout_i[1*DATA_W +: DATA_W];
        head_empty = bus.fifo_empty_i[1];
      end
      2'd2: begin
        head_data  = bus.fifo_dout_i[2*DATA_W +: DATA_W];
        head_empty = bus.fifo_empty_i[2];
      end
      default: ;
    endcase
  end

  // First non-empty channel starting at rr_ptr, wrapping mod 3.
  always_comb begin
    logic [1:0] cand;
    pick       = rr_ptr_q;
    pick_found = 1'b0;
    cand       = rr_ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (!pick_found && !bus.fifo_empty_i[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
      cand = next_ch(cand);
    end
  end

  assign valid = (state_q != StIdle) && !head_empty;
  assign xfer  = valid && bus.out_ready_i;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = pick;
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (xfer) begin
          // len payload words plus the parity word remain after the header
          cnt_d   = {1'b0, head_data[7:2]} + 7'd1;
          state_d = StBody;
        end
      end
      StBody: begin
        if (xfer) begin
          cnt_d = cnt_q - 7'd1;
          if (cnt_q == 7'd1) begin
            rr_ptr_d = next_ch(grant_q);
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (timeout) begin
      rr_ptr_d = next_ch(grant_q);
      state_d  = StIdle;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= StIdle;
      grant_q  <= 2'd0;
      rr_ptr_q <= 2'd0;
      cnt_q    <= 7'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef ROUTER_ARB_WATCHDOG_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT) + 1;

  logic [WdogW-1:0] wdog_q, wdog_d;

  // A transfer on the limit cycle takes priority over the flush.
  assign timeout = (state_q != StIdle) && !xfer && (wdog_q == WdogW'(TIMEOUT - 1));

  always_comb begin
    wdog_d = wdog_q + WdogW'(1);
    if ((state_q == StIdle) || xfer || timeout) begin
      wdog_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign bus.soft_reset_o = timeout ? ch_onehot(grant_q) : 3'b000;
`else
  assign timeout          = 1'b0;
  assign bus.soft_reset_o = 3'b000;
`endif

  assign bus.out_valid_o  = valid;
  assign bus.out_data_o   = (state_q != StIdle) ? head_data : '0;
  assign bus.out_chan_o   = grant_q;
  assign bus.out_sop_o    = valid && (state_q == StHdr);
  assign bus.out_eop_o    = valid && (state_q == StBody) && (cnt_q == 7'd1);
  assign bus.busy_o       = (state_q != StIdle);
  assign bus.fifo_rd_en_o = xfer ? ch_onehot(grant_q) : 3'b000;

endmodule
